// File: rtl/nonce_search_ctrl.sv
// rtl/nonce_search_ctrl.sv - closed-loop nonce search controller for the micro-hash datapath
module nonce_search_ctrl #(
   parameter int                   NONCE_W   = 32,
   parameter logic [NONCE_W-1:0]   MAX_NONCE = {NONCE_W{1'b1}},
   parameter int                   TIMEOUT   = 64
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [NONCE_W-1:0] nonce_init,
   input  logic [7:0]         target,
   input  logic               hash_valid,
   input  logic [23:0]        hash_in,
   output logic               block_req,
   output logic [NONCE_W-1:0] nonce,
   output logic               busy,
   output logic               found,
   output logic [NONCE_W-1:0] found_nonce,
   output logic [23:0]        found_hash,
   output logic               exhausted,
   output logic               timeout_err,
   output logic [NONCE_W-1:0] attempts
);

   // Counter only needs to reach TIMEOUT-1, where the wait gives up.
   localparam int          TW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TMO_LIM = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_FOUND,
      S_EXHAUSTED,
      S_TIMEOUT_ERR
   } state_t;

   state_t        state;
   logic [TW-1:0] tmo_cnt;
   logic          hash_pass;
   logic          last_nonce;

   // Difficulty check on the two low hash bytes; H2 does not take part.
   // Range compare on the last nonce so a start value beyond the limit
   // ends the search at its first miss instead of wrapping the space.
   always_comb begin
      hash_pass  = (hash_in[7:0] < target) && (hash_in[15:8] < target);
      last_nonce = (nonce >= MAX_NONCE);
   end

   // Search sequencer: all outputs are registered alongside the state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         tmo_cnt     <= '0;
         block_req   <= 1'b0;
         nonce       <= '0;
         busy        <= 1'b0;
         found       <= 1'b0;
         found_nonce <= '0;
         found_hash  <= '0;
         exhausted   <= 1'b0;
         timeout_err <= 1'b0;
         attempts    <= '0;
      end else begin
         block_req <= 1'b0;
         case (state)
            S_IDLE, S_FOUND, S_EXHAUSTED, S_TIMEOUT_ERR: begin
               if (start) begin
                  nonce       <= nonce_init;
                  attempts    <= '0;
                  found       <= 1'b0;
                  exhausted   <= 1'b0;
                  timeout_err <= 1'b0;
                  block_req   <= 1'b1;
                  busy        <= 1'b1;
                  state       <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               tmo_cnt <= '0;
               state   <= S_WAIT;
            end
            S_WAIT: begin
               // A result landing on the timeout limit still counts.
               if (hash_valid) begin
                  if (attempts != {NONCE_W{1'b1}}) begin
                     attempts <= attempts + 1'b1;
                  end
                  if (hash_pass) begin
                     found_nonce <= nonce;
                     found_hash  <= hash_in;
                     found       <= 1'b1;
                     busy        <= 1'b0;
                     state       <= S_FOUND;
                  end else if (last_nonce) begin
                     exhausted <= 1'b1;
                     busy      <= 1'b0;
                     state     <= S_EXHAUSTED;
                  end else begin
                     nonce     <= nonce + 1'b1;
                     block_req <= 1'b1;
                     state     <= S_ISSUE;
                  end
               end else if (tmo_cnt == TMO_LIM) begin
                  timeout_err <= 1'b1;
                  busy        <= 1'b0;
                  state       <= S_TIMEOUT_ERR;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
